// File: rtl/cpu_params_pkg.sv
// Shared CPU-side parameters: external interrupt controller sizing and register offsets.
package cpu_params_pkg;

  localparam int unsigned EXT_IRQ_NUM_SRC = 8;
  localparam int unsigned EXT_IRQ_PRIO_W  = 3;

  localparam logic [5:0] IRQ_PENDING_ADDR = 6'h20;
  localparam logic [5:0] IRQ_ENABLE_ADDR  = 6'h21;
  localparam logic [5:0] IRQ_THRESH_ADDR  = 6'h22;
  localparam logic [5:0] IRQ_CLAIM_ADDR   = 6'h23;

endpackage

// File: rtl/cpu_structs_pkg.sv
// Shared CPU-side types derived from cpu_params_pkg.
package cpu_structs_pkg;

  import cpu_params_pkg::*;

  // Source ID; value 0 means "no source".
  typedef logic [$clog2(EXT_IRQ_NUM_SRC + 1) - 1:0] IRQ_ID_T;

endpackage

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: synchronises one device line and turns level/edge requests
// into a single pending bit with claim/complete handshake.
module irq_gateway (
  input  logic clk_in,
  input  logic reset_in,
  input  logic src_raw,
  input  logic edge_mode,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic pending
);

  logic meta_q, sync_q, prev_q;
  logic pending_q, pending_d;
  logic in_service_q, in_service_d;
  logic edge_latched_q, edge_latched_d;
  logic rise;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      meta_q         <= 1'b0;
      sync_q         <= 1'b0;
      prev_q         <= 1'b0;
      pending_q      <= 1'b0;
      in_service_q   <= 1'b0;
      edge_latched_q <= 1'b0;
    end else begin
      meta_q         <= src_raw;
      sync_q         <= meta_q;
      prev_q         <= sync_q;
      pending_q      <= pending_d;
      in_service_q   <= in_service_d;
      edge_latched_q <= edge_latched_d;
    end
  end

  assign rise = sync_q & ~prev_q;

  always_comb begin
    pending_d      = pending_q;
    in_service_d   = in_service_q;
    edge_latched_d = edge_latched_q;
    if (claim_hit) begin
      pending_d    = 1'b0;
      in_service_d = 1'b1;
    end else if (complete_hit && in_service_q) begin
      // An edge seen while in service, or arriving right now, re-pends at completion.
      in_service_d   = 1'b0;
      edge_latched_d = 1'b0;
      if (edge_mode && (edge_latched_q || rise)) begin
        pending_d = 1'b1;
      end
    end else if (edge_mode) begin
      if (rise) begin
        if (in_service_q) begin
          edge_latched_d = 1'b1;
        end else if (!pending_q) begin
          pending_d = 1'b1;
        end
      end
    end else if (sync_q && !pending_q && !in_service_q) begin
      pending_d = 1'b1;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/ext_irq_ctrl.sv
// Platform-level external interrupt controller: gateways, priority arbitration with
// enable/threshold, claim/complete register port and registered ext_irq to the CPU.
module ext_irq_ctrl
  import cpu_params_pkg::*;
#(
  parameter int unsigned          NUM_SRC   = EXT_IRQ_NUM_SRC,
  parameter int unsigned          PRIO_W    = EXT_IRQ_PRIO_W,
  parameter logic [NUM_SRC-1:0]   EDGE_MASK = '0,
  parameter int unsigned          ID_W      = $clog2(NUM_SRC + 1)
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic               reg_req,
  input  logic               reg_wr,
  input  logic [5:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic               reg_ack,
  output logic [31:0]        reg_rdata,
  output logic               ext_irq
);

  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [NUM_SRC-1:0] enable_q;
  logic [PRIO_W-1:0]  threshold_q;
  logic [NUM_SRC-1:0] pending, claim_hit, complete_hit;
  logic [ID_W-1:0]    best_id;
  logic [PRIO_W-1:0]  best_prio;
  logic               rd_en, wr_en, claim_fire, complete_fire;
  logic [31:0]        rdata_d, rdata_q;
  logic               ack_q, irq_q;
  logic               unused_wdata;

  assign rd_en         = reg_req & ~reg_wr;
  assign wr_en         = reg_req & reg_wr;
  assign unused_wdata  = ^reg_wdata;

  // Strict '>' against a running best seeded with the threshold gives lowest-ID tie-break.
  always_comb begin
    best_id   = '0;
    best_prio = threshold_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending[i] && enable_q[i] && (prio_q[i] > best_prio)) begin
        best_id   = ID_W'(i + 1);
        best_prio = prio_q[i];
      end
    end
  end

  assign claim_fire    = rd_en && (reg_addr == IRQ_CLAIM_ADDR) && (best_id != '0);
  assign complete_fire = wr_en && (reg_addr == IRQ_CLAIM_ADDR);

  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_hit[i]    = claim_fire && (best_id == ID_W'(i + 1));
      complete_hit[i] = complete_fire && (reg_wdata[ID_W-1:0] == ID_W'(i + 1));
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
    irq_gateway u_gw (
      .clk_in       (clk_in),
      .reset_in     (reset_in),
      .src_raw      (src_in[g]),
      .edge_mode    (EDGE_MASK[g]),
      .claim_hit    (claim_hit[g]),
      .complete_hit (complete_hit[g]),
      .pending      (pending[g])
    );
  end

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (reg_addr)
        IRQ_PENDING_ADDR: rdata_d = 32'(pending);
        IRQ_ENABLE_ADDR:  rdata_d = 32'(enable_q);
        IRQ_THRESH_ADDR:  rdata_d = 32'(threshold_q);
        IRQ_CLAIM_ADDR:   rdata_d = 32'(best_id);
        default: begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (reg_addr == 6'(i)) rdata_d = 32'(prio_q[i]);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
      enable_q    <= '0;
      threshold_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (reg_addr == 6'(i)) prio_q[i] <= reg_wdata[PRIO_W-1:0];
      end
      if (reg_addr == IRQ_ENABLE_ADDR) enable_q    <= reg_wdata[NUM_SRC-1:0];
      if (reg_addr == IRQ_THRESH_ADDR) threshold_q <= reg_wdata[PRIO_W-1:0];
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      ack_q   <= reg_req;
      rdata_q <= rdata_d;
      irq_q   <= (best_id != '0);
    end
  end

  assign reg_ack   = ack_q;
  assign reg_rdata = rdata_q;
  assign ext_irq   = irq_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Self-checking bench for ext_irq_ctrl: directed scenarios plus random traffic against a
// behavioural model of sources, gateways and arbitration.
module tb_ext_irq_ctrl;

  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;

  localparam int N = 8;
  localparam logic [N-1:0] EDGE = 8'h01;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic [N-1:0] src_in = '0;
  logic        reg_req = 1'b0;
  logic        reg_wr = 1'b0;
  logic [5:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic        reg_ack;
  logic [31:0] reg_rdata;
  logic        ext_irq;

  ext_irq_ctrl #(
    .NUM_SRC   (N),
    .PRIO_W    (3),
    .EDGE_MASK (EDGE)
  ) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .src_in    (src_in),
    .reg_req   (reg_req),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_ack   (reg_ack),
    .reg_rdata (reg_rdata),
    .ext_irq   (ext_irq)
  );

  always #5 clk_in = ~clk_in;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state
  bit [N-1:0]   m_pend, m_insvc, m_elat, m_en;
  int           m_prio [N];
  int           m_thr;
  logic [N-1:0] src_log [$];   // [0]=prev, [1]=synchronised, [2]=first flop
  logic         exp_ack, exp_irq;
  logic [31:0]  exp_rdata;

  logic [5:0] addrs [13] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                             6'h20, 6'h21, 6'h22, 6'h23, 6'h30};

  function automatic int m_best();
    for (int p = 7; p > m_thr; p--)
      for (int id = 1; id <= N; id++)
        if (m_pend[id-1] && m_en[id-1] && m_prio[id-1] == p) return id;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [5:0] a);
    if (a < 6'(N)) return 32'(m_prio[int'(a)]);
    if (a == IRQ_PENDING_ADDR) return 32'(m_pend);
    if (a == IRQ_ENABLE_ADDR) return 32'(m_en);
    if (a == IRQ_THRESH_ADDR) return 32'(m_thr);
    if (a == IRQ_CLAIM_ADDR) return 32'(m_best());
    return 32'h0;
  endfunction

  task automatic m_reset();
    m_pend = '0; m_insvc = '0; m_elat = '0; m_en = '0; m_thr = 0;
    for (int i = 0; i < N; i++) m_prio[i] = 0;
    src_log = {8'h00, 8'h00, 8'h00};
    exp_ack = 1'b0; exp_irq = 1'b0; exp_rdata = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic req, input logic wr, input logic [5:0] addr,
                      input logic [31:0] wdata);
    int         best;
    bit         claim;
    IRQ_ID_T    cid;
    logic [N-1:0] sync, prev;
    bit [N-1:0] np, ni, ne;
    reg_req = req; reg_wr = wr; reg_addr = addr; reg_wdata = wdata;
    best      = m_best();
    exp_ack   = req;
    exp_rdata = (req && !wr) ? m_read(addr) : 32'h0;
    exp_irq   = (best != 0);
    claim     = req && !wr && (addr == IRQ_CLAIM_ADDR) && (best != 0);
    cid       = (req && wr && addr == IRQ_CLAIM_ADDR) ? wdata[3:0] : '0;
    sync = src_log[1];
    prev = src_log[0];
    np = m_pend; ni = m_insvc; ne = m_elat;
    for (int s = 0; s < N; s++) begin
      bit r;
      r = sync[s] & ~prev[s];
      if (claim && best == s + 1) begin
        np[s] = 1'b0; ni[s] = 1'b1;
      end else if (int'(cid) == s + 1 && m_insvc[s]) begin
        ni[s] = 1'b0; ne[s] = 1'b0;
        if (EDGE[s] && (m_elat[s] || r)) np[s] = 1'b1;
      end else if (EDGE[s]) begin
        if (r && m_insvc[s]) ne[s] = 1'b1;
        else if (r) np[s] = 1'b1;
      end else if (sync[s] && !m_insvc[s]) begin
        np[s] = 1'b1;
      end
    end
    if (req && wr) begin
      if (addr < 6'(N)) m_prio[int'(addr)] = int'(wdata[2:0]);
      if (addr == IRQ_ENABLE_ADDR) m_en = wdata[N-1:0];
      if (addr == IRQ_THRESH_ADDR) m_thr = int'(wdata[2:0]);
    end
    @(posedge clk_in);
    src_log.push_back(src_in);
    void'(src_log.pop_front());
    m_pend = np; m_insvc = ni; m_elat = ne;
    #1;
    check("ack", 32'(reg_ack), 32'(exp_ack));
    check("rdata", reg_rdata, exp_rdata);
    check("irq", 32'(ext_irq), 32'(exp_irq));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'h00, 32'h0);
  endtask

  task automatic rd(input logic [5:0] a);
    step(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic pulse_src1();
    src_in[0] = 1'b1; idle(2);
    src_in[0] = 1'b0; idle(3);
  endtask

  initial begin
    m_reset();
    #1;
    check("rst_ack", 32'(reg_ack), 32'h0);
    check("rst_rdata", reg_rdata, 32'h0);
    check("rst_irq", 32'(ext_irq), 32'h0);
    repeat (3) @(posedge clk_in);
    #1 reset_in = 1'b1;

    // Level source 3: latency, claim, re-pend on complete while still high
    wr(6'h02, 32'd5); wr(IRQ_ENABLE_ADDR, 32'h04); wr(IRQ_THRESH_ADDR, 32'd0);
    src_in[2] = 1'b1;
    idle(3); check("lat3", 32'(ext_irq), 32'h0);
    idle(1); check("lat4", 32'(ext_irq), 32'h1);
    rd(IRQ_CLAIM_ADDR); check("claim_lvl", reg_rdata, 32'd3);
    idle(1); check("irq_drop", 32'(ext_irq), 32'h0);
    wr(IRQ_CLAIM_ADDR, 32'd3);
    idle(2); check("repend", 32'(ext_irq), 32'h1);
    rd(IRQ_CLAIM_ADDR); check("claim_lvl2", reg_rdata, 32'd3);
    src_in[2] = 1'b0; idle(3);
    wr(IRQ_CLAIM_ADDR, 32'd3); idle(3);
    check("lvl_clear", 32'(ext_irq), 32'h0);

    // Equal priority tie-break, then raised priority
    wr(6'h01, 32'd4); wr(6'h04, 32'd4); wr(IRQ_ENABLE_ADDR, 32'h12);
    src_in[1] = 1'b1; src_in[4] = 1'b1; idle(4);
    rd(IRQ_CLAIM_ADDR); check("tie_first", reg_rdata, 32'd2);
    rd(IRQ_CLAIM_ADDR); check("tie_second", reg_rdata, 32'd5);
    src_in[1] = 1'b0; src_in[4] = 1'b0; idle(3);
    wr(IRQ_CLAIM_ADDR, 32'd2); wr(IRQ_CLAIM_ADDR, 32'd5); wr(6'h04, 32'd6);
    src_in[1] = 1'b1; src_in[4] = 1'b1; idle(4);
    rd(IRQ_CLAIM_ADDR); check("prio_first", reg_rdata, 32'd5);
    rd(IRQ_CLAIM_ADDR); check("prio_second", reg_rdata, 32'd2);
    src_in[1] = 1'b0; src_in[4] = 1'b0; idle(3);
    wr(IRQ_CLAIM_ADDR, 32'd5); wr(IRQ_CLAIM_ADDR, 32'd2);

    // Threshold masking on edge source 1
    wr(6'h00, 32'd4); wr(IRQ_THRESH_ADDR, 32'd4); wr(IRQ_ENABLE_ADDR, 32'h01);
    pulse_src1(); idle(1);
    check("thr_block", 32'(ext_irq), 32'h0);
    rd(IRQ_CLAIM_ADDR); check("thr_claim0", reg_rdata, 32'd0);
    wr(IRQ_THRESH_ADDR, 32'd3); check("thr_wr", 32'(ext_irq), 32'h0);
    idle(1); check("thr_irq", 32'(ext_irq), 32'h1);
    rd(IRQ_CLAIM_ADDR); check("thr_claim1", reg_rdata, 32'd1);
    wr(IRQ_CLAIM_ADDR, 32'd1); idle(2);

    // Edge merging and edge latched during service
    pulse_src1(); pulse_src1();
    rd(IRQ_CLAIM_ADDR); check("edge_claim", reg_rdata, 32'd1);
    rd(IRQ_CLAIM_ADDR); check("edge_merged", reg_rdata, 32'd0);
    pulse_src1(); check("edge_insvc", 32'(ext_irq), 32'h0);
    wr(IRQ_CLAIM_ADDR, 32'd1);
    idle(1); check("edge_relatch", 32'(ext_irq), 32'h1);
    rd(IRQ_CLAIM_ADDR); check("edge_claim2", reg_rdata, 32'd1);
    wr(IRQ_CLAIM_ADDR, 32'd1); idle(2);

    // Ignored completes, read-only PENDING, unmapped address
    wr(IRQ_ENABLE_ADDR, 32'h05); src_in[2] = 1'b1; idle(4);
    rd(IRQ_CLAIM_ADDR); check("bad_cmp_claim", reg_rdata, 32'd3);
    wr(IRQ_CLAIM_ADDR, 32'd0); wr(IRQ_CLAIM_ADDR, 32'd9);
    wr(IRQ_CLAIM_ADDR, 32'd6); wr(IRQ_CLAIM_ADDR, 32'd1);
    idle(3); check("bad_cmp_irq", 32'(ext_irq), 32'h0);
    wr(IRQ_PENDING_ADDR, 32'hFFFF_FFFF);
    rd(IRQ_PENDING_ADDR); check("pend_ro", reg_rdata, 32'h0);
    rd(6'h30); check("unmapped_rd", reg_rdata, 32'h0);
    check("unmapped_ack", 32'(reg_ack), 32'h1);
    src_in[2] = 1'b0; idle(3);
    wr(IRQ_CLAIM_ADDR, 32'd3); idle(2);

    // Asynchronous reset mid-claim with four sources pending
    for (int i = 0; i < 4; i++) wr(6'(i), 32'd1);
    wr(IRQ_THRESH_ADDR, 32'd0); wr(IRQ_ENABLE_ADDR, 32'h0F);
    src_in = 8'h0F; idle(4);
    rd(IRQ_PENDING_ADDR); check("pend_0f", reg_rdata, 32'h0F);
    rd(IRQ_CLAIM_ADDR);
    reg_req = 1'b0;
    #2 reset_in = 1'b0;
    #1;
    check("mid_rst_ack", 32'(reg_ack), 32'h0);
    check("mid_rst_irq", 32'(ext_irq), 32'h0);
    check("mid_rst_rdata", reg_rdata, 32'h0);
    src_in = '0;
    repeat (2) @(posedge clk_in);
    #1 reset_in = 1'b1;
    m_reset();
    idle(1);
    for (int i = 0; i < 13; i++) begin
      if (addrs[i] != 6'h30) begin
        rd(addrs[i]); check("post_rst_reg", reg_rdata, 32'h0);
      end
    end

    // Random traffic
    for (int i = 0; i < N; i++) wr(6'(i), 32'($urandom_range(1, 7)));
    wr(IRQ_ENABLE_ADDR, 32'hFF);
    for (int k = 0; k < 500; k++) begin
      int op;
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = int'($urandom_range(0, N - 1));
        src_in[b] = ~src_in[b];
      end
      op = int'($urandom_range(0, 9));
      case (op)
        4: rd(IRQ_CLAIM_ADDR);
        5: wr(IRQ_CLAIM_ADDR, 32'($urandom_range(0, 9)));
        6: wr(6'($urandom_range(0, N - 1)), $urandom);
        7: wr(IRQ_ENABLE_ADDR + 6'($urandom_range(0, 1)), $urandom);
        8: rd(addrs[$urandom_range(0, 12)]);
        9: wr(addrs[$urandom_range(0, 12)], $urandom);
        default: idle(1);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_irq_ctrl.md
Name: ext_irq_ctrl

Overview:
Platform-level external interrupt controller that sources the `ext_irq` line consumed by the CPU's trap/mode logic; it drives mip.meip and, with ext_S, gates seip.
- Accepts NUM_SRC asynchronous device interrupt lines and synchronises them.
- Per-source gateways turn level or edge requests into single pending bits.
- Arbitration uses per-source priority, an enable mask and a threshold.
- The M-mode handler reads a claim/complete register over a simple single-cycle register port.

Parameters:
NUM_SRC, 8, number of interrupt sources; source IDs are 1..NUM_SRC, and ID 0 means "none".
PRIO_W, 3, priority width; priority 0 never interrupts.
EDGE_MASK, '0, NUM_SRC bits; 1 = source is edge-triggered, 0 = level-triggered.
ID_W, $clog2(NUM_SRC+1), source ID width.

Ports:
clk_in  input  1  system clock
reset_in  input  1  asynchronous, active-low reset
src_in  input  NUM_SRC  raw device interrupt lines; bit i = source ID i+1; asynchronous to clk_in
reg_req  input  1  one-cycle register access request
reg_wr  input  1  1 = write, 0 = read; qualified by reg_req
reg_addr  input  6  word address
reg_wdata  input  32  write data
reg_ack  output  1  one-cycle acknowledge, one cycle after reg_req
reg_rdata  output  32  read data, valid with reg_ack, 0 otherwise
ext_irq  output  1  registered interrupt request to the CPU

Behaviour:
- Reset (reset_in=0, asynchronous):
  - All priorities, the enable mask, threshold, pending, in_service, edge_latched and synchroniser flops are 0.
  - reg_ack=0, reg_rdata=0, ext_irq=0.
- Synchroniser: 2-flop per source, giving src_sync.
- Register map (word address):
  - 0..NUM_SRC-1: PRIO[id-1], RW, bits [PRIO_W-1:0]; upper bits read 0.
  - 0x20: PENDING, RO; writes are ignored.
  - 0x21: ENABLE, RW.
  - 0x22: THRESHOLD, RW.
  - 0x23: CLAIM/COMPLETE.
  - Unmapped addresses read 0, writes are ignored, and reg_ack is still given.
- Register access timing: reg_req in cycle N gives reg_ack=1 and reg_rdata in cycle N+1. Write data takes effect at the cycle N edge.
- Gateway, level source: sets pending when src_sync=1, pending=0 and in_service=0.
- Gateway, edge source:
  - A rising edge of src_sync with pending=0 and in_service=0 sets pending.
  - An edge while pending=1 is merged (dropped).
  - An edge while in_service=1 sets edge_latched; at complete, edge_latched moves to pending.
- Candidate: the highest PRIO among sources with pending & enable & (PRIO > THRESHOLD). Ties go to the lowest ID. best_id = 0 if there is no candidate. Computed combinationally from registered state.
- ext_irq: registered (best_id != 0).
  - Latency from a src_in rise to ext_irq=1 is 4 cycles: 2 sync + 1 pending + 1 output.
- Claim (read of 0x23):
  - Returns best_id as of cycle N.
  - If best_id != 0: that source's pending is cleared and in_service is set at the same edge.
  - If best_id == 0: returns 0 with no state change.
- Complete (write of 0x23 with ID in reg_wdata[ID_W-1:0]): clears in_service[ID].
  - ID 0, ID > NUM_SRC, or an ID not in service: ignored.
  - A level source still high re-pends on the next cycle.
- Simultaneous events:
  - Gateway set and claim in the same cycle: the claim uses pre-edge pending; the new pending is visible next cycle.
  - Complete and a new edge on the same source in the same cycle: pending is set.
  - Writes to PRIO/ENABLE/THRESHOLD affect best_id from the next cycle; ext_irq follows one cycle later.
- Reset mid-operation: all state clears immediately (asynchronous). The first reg_ack after reset deassertion is only for a new reg_req.

Decomposition:
- cpu_params_pkg: EXT_IRQ_NUM_SRC and EXT_IRQ_PRIO_W, the register offset localparams (IRQ_PENDING_ADDR=6'h20, IRQ_ENABLE_ADDR=6'h21, IRQ_THRESH_ADDR=6'h22, IRQ_CLAIM_ADDR=6'h23).
- cpu_structs_pkg: typedef IRQ_ID_T.
- Sub-module irq_gateway, one instance per source:
  - Contains the synchroniser, edge detection, pending, in_service and edge_latched state.
  - Inputs: claim_hit, complete_hit, edge_mode.
  - Output: pending.

Test Plan:
- Level source 3, PRIO[2]=5, ENABLE=0x04, THRESHOLD=0; src_in[2]=1 at cycle 0 → ext_irq=1 at cycle 4; claim read → rdata=3, ext_irq=0 two cycles later; complete 3 with the source still high → ext_irq=1 again.
- Sources 2 and 5 pending, PRIO=4 and 4 → claim returns 2; next claim returns 5; PRIO[4]=6 before the first claim → claim returns 5 first.
- THRESHOLD=4 with source 1 at PRIO=4 → ext_irq stays 0 and claim returns 0; THRESHOLD=3 → ext_irq=1 two cycles after the write.
- Edge source 1 (EDGE_MASK=1): two pulses before claim → one claim of 1, then claim returns 0; a pulse during in_service → after complete 1, ext_irq reasserts and claim returns 1.
- Complete with ID 0, ID 9 and an unclaimed ID → no state change; write to PENDING ignored; read of address 0x30 → rdata=0 with reg_ack.
- reset_in low asynchronously mid-claim with pending=0x0F → pending, ext_irq and reg_ack are 0 immediately; after release, all registers read 0.
